ram_tcam_prio: RTL and testbench

Parametrised successor to the stitched RAM-based ternary CAM. Block width, block count and depth are configurable. The block adds per-entry valid bits, a single-cycle erase command, a fully pipelined lookup path and a lowest-index priority encoder that returns the matching address instead of raw match lines. It sits between the packet-classification front end and the action table, which is indexed by `match_addr`.

---
 rtl/ram_tcam_prio.sv | 179 +++++++++++++++++
 tb/tb_ram_tcam_prio.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_tcam_prio.sv
// ram_tcam_prio: RAM-stitched ternary CAM with per-entry valid bits, erase and a
// lowest-index priority encoder. Define TCAM_MULTIHIT_EN to build the multi-hit detect.
module ram_tcam_prio #(
    parameter int unsigned DATA_BLOCKS = 5,
    parameter int unsigned BLOCK_BITS  = 7,
    parameter int unsigned ADDR_WIDTH  = 5
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_write_i,
    input  logic                              erase_i,
    input  logic [ADDR_WIDTH-1:0]             waddr_i,
    input  logic [DATA_BLOCKS*BLOCK_BITS-1:0] wdata_i,
    input  logic [DATA_BLOCKS*BLOCK_BITS-1:0] wcare_i,
    input  logic                              lookup_valid_i,
    input  logic [DATA_BLOCKS*BLOCK_BITS-1:0] lookup_data_i,
    output logic                              ready_o,
    output logic                              result_valid_o,
    output logic                              match_found_o,
    output logic [ADDR_WIDTH-1:0]             match_addr_o,
    output logic                              multi_hit_o
);

    localparam int unsigned DATA_WIDTH = DATA_BLOCKS * BLOCK_BITS;
    localparam int unsigned WORDS      = 2 ** ADDR_WIDTH;
    localparam int unsigned ROWS       = 2 ** BLOCK_BITS;

    typedef enum logic {StIdle, StSweep} state_e;

    state_e                  state_q, state_d;
    logic [BLOCK_BITS-1:0]   cnt_q, cnt_d;
    logic [WORDS-1:0]        valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, wcare_q;
    logic                    erase_pend_q;
    logic [ADDR_WIDTH-1:0]   erase_addr_q;
    logic                    s1_valid_q;
    logic                    result_valid_q, match_found_q;
    logic [ADDR_WIDTH-1:0]   match_addr_q;

    logic                    write_acc, erase_acc, lookup_acc;
    logic [DATA_BLOCKS-1:0]  sweep_bit;
    logic [WORDS-1:0]        match;
    logic [ADDR_WIDTH-1:0]   hit_addr;

    logic [WORDS-1:0]        ram_q [DATA_BLOCKS][ROWS];
    logic [WORDS-1:0]        rd_q  [DATA_BLOCKS];

    assign ready_o    = (state_q == StIdle);
    assign write_acc  = start_write_i & ready_o;
    assign erase_acc  = erase_i & ready_o & ~start_write_i;
    assign lookup_acc = lookup_valid_i & ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        // Erase lands one edge late so a lookup accepted alongside it still sees the entry.
        if (erase_pend_q) begin
            valid_d[erase_addr_q] = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                if (write_acc) begin
                    state_d          = StSweep;
                    cnt_d            = '0;
                    valid_d[waddr_i] = 1'b0;
                end
            end
            StSweep: begin
                cnt_d = cnt_q + BLOCK_BITS'(1);
                if (cnt_q == '1) begin
                    state_d          = StIdle;
                    valid_d[waddr_q] = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            valid_q      <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wcare_q      <= '0;
            erase_pend_q <= 1'b0;
            erase_addr_q <= '0;
            s1_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            erase_pend_q <= erase_acc;
            s1_valid_q   <= lookup_acc;
            if (write_acc) begin
                waddr_q <= waddr_i;
                wdata_q <= wdata_i;
                wcare_q <= wcare_i;
            end
            if (erase_acc) begin
                erase_addr_q <= waddr_i;
            end
        end
    end

    always_comb begin
        sweep_bit = '0;
        for (int s = 0; s < int'(DATA_BLOCKS); s++) begin
            sweep_bit[s] = ((cnt_q ^ wdata_q[s*BLOCK_BITS +: BLOCK_BITS])
                            & wcare_q[s*BLOCK_BITS +: BLOCK_BITS]) == '0;
        end
    end

    // Slice RAMs: not reset, stale rows are masked by valid_q.
    always_ff @(posedge clk_i) begin
        if (state_q == StSweep) begin
            for (int s = 0; s < int'(DATA_BLOCKS); s++) begin
                ram_q[s][cnt_q][waddr_q] <= sweep_bit[s];
            end
        end
        if (lookup_acc) begin
            for (int s = 0; s < int'(DATA_BLOCKS); s++) begin
                rd_q[s] <= ram_q[s][lookup_data_i[s*BLOCK_BITS +: BLOCK_BITS]];
            end
        end
    end

    always_comb begin
        match = valid_q;
        for (int s = 0; s < int'(DATA_BLOCKS); s++) begin
            match = match & rd_q[s];
        end
        hit_addr = '0;
        for (int e = int'(WORDS) - 1; e >= 0; e--) begin
            if (match[e]) begin
                hit_addr = ADDR_WIDTH'(e);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_valid_q <= 1'b0;
            match_found_q  <= 1'b0;
            match_addr_q   <= '0;
        end else begin
            result_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                match_found_q <= |match;
                match_addr_q  <= hit_addr;
            end
        end
    end

`ifdef TCAM_MULTIHIT_EN
    logic multi_hit_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            multi_hit_q <= 1'b0;
        end else if (s1_valid_q) begin
            // Clearing the lowest set bit leaves something only if two or more hit.
            multi_hit_q <= |(match & (match - WORDS'(1)));
        end
    end

    assign multi_hit_o = multi_hit_q;
`else
    assign multi_hit_o = 1'b0;
`endif

    assign result_valid_o = result_valid_q;
    assign match_found_o  = match_found_q;
    assign match_addr_o   = match_addr_q;

endmodule

// File: tb/tb_ram_tcam_prio.sv
// Scoreboard bench for ram_tcam_prio: expected lookups are queued at drive time and
// popped by a monitor when result_valid_o pulses.
module tb_ram_tcam_prio;

    localparam int DB    = 5;
    localparam int BB    = 7;
    localparam int AW    = 5;
    localparam int DW    = DB * BB;
    localparam int WORDS = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_write = 1'b0;
    logic          erase = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] wcare = '0;
    logic          lookup_valid = 1'b0;
    logic [DW-1:0] lookup_data = '0;
    logic          ready, result_valid, match_found, multi_hit;
    logic [AW-1:0] match_addr;

    ram_tcam_prio #(
        .DATA_BLOCKS(DB),
        .BLOCK_BITS (BB),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_write_i (start_write),
        .erase_i       (erase),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .wcare_i       (wcare),
        .lookup_valid_i(lookup_valid),
        .lookup_data_i (lookup_data),
        .ready_o       (ready),
        .result_valid_o(result_valid),
        .match_found_o (match_found),
        .match_addr_o  (match_addr),
        .multi_hit_o   (multi_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          found;
        logic [AW-1:0] addr;
        logic          multi;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [DW-1:0] m_data  [WORDS];
    logic [DW-1:0] m_care  [WORDS];
    logic          m_valid [WORDS];
    logic [DW-1:0] ones = {DW{1'b1}};

    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [DW-1:0] key, input int due);
        exp_t r;
        int   hits;
        r.found = 1'b0;
        r.addr  = '0;
        r.multi = 1'b0;
        r.due   = due;
        hits    = 0;
        for (int e = 0; e < WORDS; e++) begin
            if (m_valid[e] && (((key ^ m_data[e]) & m_care[e]) == '0)) begin
                if (hits == 0) r.addr = AW'(e);
                hits++;
            end
        end
        r.found = (hits > 0);
`ifdef TCAM_MULTIHIT_EN
        r.multi = (hits > 1);
`endif
        return r;
    endfunction

    // Monitor: every result pulse must match the oldest queued expectation at its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (result_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got result_valid=1 at cyc %0d, want none",
                             cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if ({match_found, match_addr, multi_hit} !== {mon_e.found, mon_e.addr, mon_e.multi}
                        || cyc != mon_e.due) begin
                        n_err++;
                        $display("FAIL lookup_result: got found=%0d addr=%0d multi=%0d cyc=%0d, want found=%0d addr=%0d multi=%0d cyc=%0d",
                                 match_found, match_addr, multi_hit, cyc,
                                 mon_e.found, mon_e.addr, mon_e.multi, mon_e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_result: got no result_valid by cyc %0d, want one at cyc %0d",
                         cyc, mon_e.due);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [DW-1:0] key);
        lookup_valid = 1'b1;
        lookup_data  = key;
        sb.push_back(model(key, cyc + 2));
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    endtask

    // Drives the write command for one cycle; caller performs the step.
    task automatic write_start(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] c);
        start_write = 1'b1;
        waddr       = a;
        wdata       = d;
        wcare       = c;
        m_data[a]   = d;
        m_care[a]   = c;
        m_valid[a]  = 1'b0;
    endtask

    task automatic wait_write_done(input int already, input logic [AW-1:0] a);
        int busy;
        busy = already;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready) break;
            busy++;
        end
        n_cmp++;
        if (busy != 128) begin
            n_err++;
            $display("FAIL write_busy: got ready low %0d cycles, want 128", busy);
        end
        m_valid[a] = 1'b1;
        step();
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ready: got %b, want 1", name, ready);
        end
        n_cmp++;
        if (result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_result_valid: got %b, want 0", name, result_valid);
        end
        n_cmp++;
        if ({match_found, match_addr, multi_hit} !== '0) begin
            n_err++;
            $display("FAIL %s_outputs: got found=%b addr=%0d multi=%b, want 0/0/0",
                     name, match_found, match_addr, multi_hit);
        end
    endtask

    task automatic test_reset();
        for (int e = 0; e < WORDS; e++) m_valid[e] = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        do_lookup('0);
        drain();
    endtask

    task automatic test_exact();
        write_start(5'd3, 35'h1_2345_6789, ones);
        step();
        start_write = 1'b0;
        wait_write_done(0, 5'd3);
        do_lookup(35'h1_2345_6789);
        do_lookup(35'h1_2345_6788);
        drain();
    endtask

    task automatic test_dont_care();
        write_start(5'd7, 35'h4_0F0F_1234, '0);
        step();
        start_write = 1'b0;
        wait_write_done(0, 5'd7);
        write_start(5'd2, 35'hABC, ones);
        step();
        start_write = 1'b0;
        wait_write_done(0, 5'd2);
        do_lookup(35'hABC);
        do_lookup(35'h5);
        do_lookup(35'h1_2345_6789);
        drain();
    endtask

    task automatic test_erase();
        erase        = 1'b1;
        waddr        = 5'd2;
        lookup_valid = 1'b1;
        lookup_data  = 35'hABC;
        sb.push_back(model(35'hABC, cyc + 2));
        step();
        erase        = 1'b0;
        lookup_valid = 1'b0;
        m_valid[2]   = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL erase_ready: got %b, want 1", ready);
        end
        do_lookup(35'hABC);
        do_lookup(35'hABC);
        drain();
    endtask

    task automatic test_back_to_back();
        write_start(5'd7, 35'h55, ones);
        lookup_valid = 1'b1;
        lookup_data  = 35'h1_2345_6789;
        sb.push_back(model(35'h1_2345_6789, cyc + 2));
        step();
        start_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lookup_data = DW'(i * 3 + 1);
            step();
        end
        lookup_valid = 1'b0;
        wait_write_done(5, 5'd7);
        do_lookup(35'h55);
        do_lookup(35'h1_2345_6789);
        do_lookup(35'h56);
        do_lookup(35'hABC);
        drain();
    endtask

    task automatic test_reset_mid_sweep();
        write_start(5'd9, 35'h77, ones);
        step();
        start_write = 1'b0;
        repeat (50) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("sweep_reset");
        for (int e = 0; e < WORDS; e++) m_valid[e] = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        do_lookup(35'h77);
        do_lookup(35'h1_2345_6789);
        drain();
        // A lookup in flight when reset hits must never produce a result.
        write_start(5'd4, 35'h99, ones);
        step();
        start_write = 1'b0;
        wait_write_done(0, 5'd4);
        do_lookup(35'h99);
        drain();
        lookup_valid = 1'b1;
        lookup_data  = 35'h99;
        step();
        lookup_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("flush_reset");
        for (int e = 0; e < WORDS; e++) m_valid[e] = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        do_lookup(35'h99);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cyc %0d, want bench completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_exact();
        test_dont_care();
        test_erase();
        test_back_to_back();
        test_reset_mid_sweep();
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
